// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory-bus arbiter and its address decoder.
package mem_bus_arbiter_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned XW = 5;

  // Address map, compared against addr[15:0]
  localparam logic [15:0] DM_BASE    = 16'h0000;
  localparam logic [15:0] DM_LIMIT   = 16'h2FFF;
  localparam logic [15:0] DEV0_BASE  = 16'h7F00;
  localparam logic [15:0] DEV0_LIMIT = 16'h7F0B;
  localparam logic [15:0] DEV1_BASE  = 16'h7F10;
  localparam logic [15:0] DEV1_LIMIT = 16'h7F1B;

  // MIPS exception codes returned to the master
  localparam logic [XW-1:0] EXC_NONE = 5'd0;
  localparam logic [XW-1:0] EXC_ADEL = 5'd4;
  localparam logic [XW-1:0] EXC_ADES = 5'd5;
  localparam logic [XW-1:0] EXC_DBE  = 5'd7;

  typedef enum logic [2:0] {IDLE, ERR, DM, DEV, RESP} state_t;

  typedef enum logic [1:0] {RGN_NONE, RGN_DM, RGN_DEV0, RGN_DEV1} region_t;

  // One master's request payload
  typedef struct packed {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_req_t;

  // Inclusive range test on the low address half
  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational region decode and access-error classification for one request.
module mem_addr_decode
  import mem_bus_arbiter_pkg::*;
(
  input  logic [15:0]   addr,
  input  logic [BW-1:0] be,
  input  logic          we,
  output region_t       region,
  output logic [XW-1:0] exc
);

  logic is_dev;
  logic bad;

  // Map the low address half onto a slave region
  always_comb begin
    region = RGN_NONE;
    if (in_range(addr, DM_BASE, DM_LIMIT))
      region = RGN_DM;
    else if (in_range(addr, DEV0_BASE, DEV0_LIMIT))
      region = RGN_DEV0;
    else if (in_range(addr, DEV1_BASE, DEV1_LIMIT))
      region = RGN_DEV1;
  end

  // Unmapped, partial device access, or misaligned word access is an address error
  always_comb begin
    is_dev = (region == RGN_DEV0) || (region == RGN_DEV1);
    bad    = (region == RGN_NONE)
          || (is_dev && (be != 4'b1111))
          || ((be == 4'b1111) && (addr[1:0] != 2'b00));
    exc    = bad ? (we ? EXC_ADES : EXC_ADEL) : EXC_NONE;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master data-bus arbiter sequencing one access at a time to DM or a timer device.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [BW-1:0] m0_be,
  input  logic [BW-1:0] m1_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_done,
  output logic          m1_done,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [XW-1:0] m0_exc,
  output logic [XW-1:0] m1_exc,
  output logic          dm_en,
  output logic          dm_we,
  output logic [BW-1:0] dm_be,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  output logic [1:0]    dev_cs,
  output logic          dev_we,
  output logic [AW-1:0] dev_addr,
  output logic [DW-1:0] dev_wdata,
  input  logic [DW-1:0] dev_rdata0,
  input  logic [DW-1:0] dev_rdata1,
  input  logic          dev_ready0,
  input  logic          dev_ready1
);

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              last_grant_q, last_grant_n;
  logic              owner_q, owner_n;
  logic              dm_rd_q, dm_rd_n;
  logic [DW-1:0]     resp_rdata_q, resp_rdata_n;
  logic [XW-1:0]     resp_exc_q, resp_exc_n;
  logic [1:0]        gnt_q, gnt_n;
  logic [1:0]        done_q, done_n;
  logic [1:0][DW-1:0] rdata_q, rdata_n;
  logic [1:0][XW-1:0] exc_q, exc_n;
  logic              dm_en_q, dm_en_n;
  logic              dm_we_q, dm_we_n;
  logic [BW-1:0]     dm_be_q, dm_be_n;
  logic [AW-1:0]     dm_addr_q, dm_addr_n;
  logic [DW-1:0]     dm_wdata_q, dm_wdata_n;
  logic [1:0]        dev_cs_q, dev_cs_n;
  logic              dev_we_q, dev_we_n;
  logic [AW-1:0]     dev_addr_q, dev_addr_n;
  logic [DW-1:0]     dev_wdata_q, dev_wdata_n;

  bus_req_t      req0, req1, sel;
  logic          win;
  region_t       sel_region;
  logic [XW-1:0] sel_exc;
  logic          dev_ready_c;
  logic [DW-1:0] dev_rdata_c;

  // Pick the winning master: the sole requester, or on a tie the one not granted last
  always_comb begin
    req0 = '{we: m0_we, be: m0_be, addr: m0_addr, wdata: m0_wdata};
    req1 = '{we: m1_we, be: m1_be, addr: m1_addr, wdata: m1_wdata};
    if (m0_req && m1_req) win = ~last_grant_q;
    else                  win = ~m0_req;
    sel = win ? req1 : req0;
  end

  mem_addr_decode u_decode (
    .addr   (sel.addr[15:0]),
    .be     (sel.be),
    .we     (sel.we),
    .region (sel_region),
    .exc    (sel_exc)
  );

  // Response from whichever device is currently selected
  always_comb begin
    dev_ready_c = dev_cs_q[0] ? dev_ready0 : dev_ready1;
    dev_rdata_c = dev_cs_q[0] ? dev_rdata0 : dev_rdata1;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    last_grant_n = last_grant_q;
    owner_n      = owner_q;
    dm_rd_n      = dm_rd_q;
    resp_rdata_n = resp_rdata_q;
    resp_exc_n   = resp_exc_q;
    gnt_n        = gnt_q;
    done_n       = '0;
    rdata_n      = rdata_q;
    exc_n        = exc_q;
    dm_en_n      = 1'b0;
    dm_we_n      = 1'b0;
    dm_be_n      = '0;
    dm_addr_n    = '0;
    dm_wdata_n   = '0;
    dev_cs_n     = dev_cs_q;
    dev_we_n     = dev_we_q;
    dev_addr_n   = dev_addr_q;
    dev_wdata_n  = dev_wdata_q;

    case (state_q)
      IDLE: begin
        // The done cycle still belongs to the finished transaction; accept afterwards
        if (|done_q) begin
          gnt_n = '0;
        end else if (m0_req || m1_req) begin
          owner_n      = win;
          last_grant_n = win;
          gnt_n        = win ? 2'b10 : 2'b01;
          cnt_n        = '0;
          dm_rd_n      = 1'b0;
          resp_exc_n   = sel_exc;
          resp_rdata_n = '0;
          if (sel_exc != EXC_NONE) begin
            state_n = ERR;
          end else if (sel_region == RGN_DM) begin
            state_n    = DM;
            dm_en_n    = 1'b1;
            dm_we_n    = sel.we;
            dm_be_n    = sel.be;
            dm_addr_n  = sel.addr;
            dm_wdata_n = sel.wdata;
            dm_rd_n    = ~sel.we;
          end else begin
            state_n     = DEV;
            dev_cs_n    = (sel_region == RGN_DEV0) ? 2'b01 : 2'b10;
            dev_we_n    = sel.we;
            dev_addr_n  = sel.addr;
            dev_wdata_n = sel.wdata;
          end
        end
      end
      ERR: state_n = RESP;
      DM:  state_n = RESP;
      DEV: begin
        // Ready wins over a simultaneous timeout
        if (dev_ready_c || (cnt_q == CW'(TIMEOUT - 1))) begin
          state_n      = RESP;
          resp_rdata_n = (dev_ready_c && !dev_we_q) ? dev_rdata_c : '0;
          resp_exc_n   = dev_ready_c ? EXC_NONE : EXC_DBE;
          dev_cs_n     = '0;
          dev_we_n     = 1'b0;
          dev_addr_n   = '0;
          dev_wdata_n  = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_n          = IDLE;
        done_n[owner_q]  = 1'b1;
        rdata_n[owner_q] = dm_rd_q ? dm_rdata : resp_rdata_q;
        exc_n[owner_q]   = resp_exc_q;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      dm_rd_q      <= 1'b0;
      resp_rdata_q <= '0;
      resp_exc_q   <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      exc_q        <= '0;
      dm_en_q      <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_be_q      <= '0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dev_cs_q     <= '0;
      dev_we_q     <= 1'b0;
      dev_addr_q   <= '0;
      dev_wdata_q  <= '0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      last_grant_q <= last_grant_n;
      owner_q      <= owner_n;
      dm_rd_q      <= dm_rd_n;
      resp_rdata_q <= resp_rdata_n;
      resp_exc_q   <= resp_exc_n;
      gnt_q        <= gnt_n;
      done_q       <= done_n;
      rdata_q      <= rdata_n;
      exc_q        <= exc_n;
      dm_en_q      <= dm_en_n;
      dm_we_q      <= dm_we_n;
      dm_be_q      <= dm_be_n;
      dm_addr_q    <= dm_addr_n;
      dm_wdata_q   <= dm_wdata_n;
      dev_cs_q     <= dev_cs_n;
      dev_we_q     <= dev_we_n;
      dev_addr_q   <= dev_addr_n;
      dev_wdata_q  <= dev_wdata_n;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign m0_exc    = exc_q[0];
  assign m1_exc    = exc_q[1];
  assign dm_en     = dm_en_q;
  assign dm_we     = dm_we_q;
  assign dm_be     = dm_be_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dev_cs    = dev_cs_q;
  assign dev_we    = dev_we_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [4:0]  m0_exc, m1_exc;
  logic        dm_en, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dev_cs;
  logic        dev_we;
  logic [31:0] dev_addr, dev_wdata, dev_rdata0, dev_rdata1;
  logic        dev_ready0, dev_ready1;

  logic [31:0] dm_ret;
  int          checks = 0;
  int          errors = 0;
  int          dm_en_cnt = 0;
  int          dev_cs_cnt = 0;
  int          both_gnt_cnt = 0;

  mem_bus_arbiter #(.TIMEOUT(16), .CW(5)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_be(m0_be), .m1_be(m1_be), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_exc(m0_exc), .m1_exc(m1_exc),
    .dm_en(dm_en), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dev_cs(dev_cs), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata0(dev_rdata0), .dev_rdata1(dev_rdata1),
    .dev_ready0(dev_ready0), .dev_ready1(dev_ready1)
  );

  always #5 clk = ~clk;

  // DM model: read data appears the cycle after the strobe
  always @(posedge clk) dm_rdata <= (dm_en && !dm_we) ? dm_ret : 32'h0;

  // Activity monitors
  always @(posedge clk) begin
    if (dm_en) dm_en_cnt <= dm_en_cnt + 1;
    if (dev_cs != 2'b00) dev_cs_cnt <= dev_cs_cnt + 1;
    if (m0_gnt && m1_gnt) both_gnt_cnt <= both_gnt_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
  endtask

  initial begin
    int base_dm, base_dev, nd, seq, cyc, n0, n, any_done;
    reset = 1'b1;
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    dm_ret = 32'h0;
    dev_rdata0 = 32'h0; dev_rdata1 = 32'h0;
    dev_ready0 = 1'b0; dev_ready1 = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk("rst_done", {30'h0, m1_done, m0_done}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_exc", {22'h0, m1_exc, m0_exc}, 32'h0);
    chk("rst_dm_en", {31'h0, dm_en}, 32'h0);
    chk("rst_dev_cs", {30'h0, dev_cs}, 32'h0);
    reset = 1'b0;
    tick();

    // m0 lw from DM
    dm_ret = 32'hDEADBEEF;
    base_dm = dm_en_cnt;
    set_m0(1, 0, 4'hF, 32'h0000_1004, 32'h0);
    tick();
    chk("lw_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    chk("lw_dm_en", {31'h0, dm_en}, 32'h1);
    chk("lw_dm_addr", dm_addr, 32'h0000_1004);
    chk("lw_dm_we_be", {27'h0, dm_we, dm_be}, 32'h0F);
    tick();
    chk("lw_dm_en_drop", {31'h0, dm_en}, 32'h0);
    chk("lw_early_done", {31'h0, m0_done}, 32'h0);
    tick();
    chk("lw_done", {31'h0, m0_done}, 32'h1);
    chk("lw_rdata", m0_rdata, 32'hDEADBEEF);
    chk("lw_exc", {27'h0, m0_exc}, 32'h0);
    chk("lw_m1_done", {31'h0, m1_done}, 32'h0);
    m0_req = 1'b0;
    tick();
    chk("lw_done_pulse", {31'h0, m0_done}, 32'h0);
    chk("lw_gnt_drop", {31'h0, m0_gnt}, 32'h0);
    chk("lw_rdata_hold", m0_rdata, 32'hDEADBEEF);
    chk("lw_dm_en_once", dm_en_cnt - base_dm, 32'd1);

    // m0 sh to a device: partial write is AdES, no strobe
    base_dm = dm_en_cnt;
    base_dev = dev_cs_cnt;
    set_m0(1, 1, 4'b0011, 32'h0000_7F04, 32'h0000_1234);
    tick(); tick(); tick();
    chk("sh_done", {31'h0, m0_done}, 32'h1);
    chk("sh_exc", {27'h0, m0_exc}, 32'd5);
    m0_req = 1'b0;
    tick();
    chk("sh_no_strobe", (dm_en_cnt - base_dm) + (dev_cs_cnt - base_dev), 32'd0);

    // m1 lw to unmapped 0x3000: AdEL
    set_m1(1, 0, 4'hF, 32'h0000_3000, 32'h0);
    tick(); tick(); tick();
    chk("unm_done", {30'h0, m1_done, m0_done}, 32'h2);
    chk("unm_exc", {27'h0, m1_exc}, 32'd4);
    chk("unm_m0_exc_hold", {27'h0, m0_exc}, 32'd5);
    m1_req = 1'b0;
    tick();

    // Both masters request DM back-to-back: expect m0, m1, m0
    dm_ret = 32'h1111_2222;
    set_m0(1, 0, 4'hF, 32'h0000_0100, 32'h0);
    set_m1(1, 0, 4'hF, 32'h0000_0200, 32'h0);
    nd = 0; seq = 0; cyc = 0; n0 = 0;
    while (nd < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (m0_done) begin
        nd++; seq = seq * 10 + 1; n0++;
        if (n0 == 2) m0_req = 1'b0;
      end
      if (m1_done) begin
        nd++; seq = seq * 10 + 2;
        m1_req = 1'b0;
      end
    end
    chk("b2b_done_count", nd, 32'd3);
    chk("b2b_order", seq, 32'd121);
    chk("b2b_m1_rdata", m1_rdata, 32'h1111_2222);
    tick(); tick(); tick(); tick();
    chk("b2b_no_extra_done", {30'h0, m1_done, m0_done}, 32'h0);
    chk("b2b_gnt_exclusive", both_gnt_cnt, 32'd0);

    // m0 sw to DEV1, ready in DEV cycle 3
    set_m0(1, 1, 4'hF, 32'h0000_7F14, 32'hCAFE_F00D);
    tick();
    chk("sw_dev_fields", {31'h0, dev_we}, 32'h1);
    chk("sw_dev_addr", dev_addr, 32'h0000_7F14);
    chk("sw_dev_wdata", dev_wdata, 32'hCAFE_F00D);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (dev_cs == 2'b10) n++;
      if (k == 3) dev_ready1 = 1'b1;
      tick();
    end
    dev_ready1 = 1'b0;
    chk("sw_dev_cs_cycles", n, 32'd4);
    chk("sw_dev_cs_drop", {30'h0, dev_cs}, 32'h0);
    chk("sw_early_done", {31'h0, m0_done}, 32'h0);
    tick();
    chk("sw_done", {31'h0, m0_done}, 32'h1);
    chk("sw_exc", {27'h0, m0_exc}, 32'h0);
    m0_req = 1'b0;
    tick();

    // m1 lw from DEV0 that never answers: bus error after TIMEOUT cycles
    dev_rdata0 = 32'h5555_5555;
    set_m1(1, 0, 4'hF, 32'h0000_7F00, 32'h0);
    tick();
    n = 0;
    while (dev_cs == 2'b01 && n < 40) begin
      n++;
      tick();
    end
    chk("to_dev_cs_cycles", n, 32'd16);
    chk("to_early_done", {31'h0, m1_done}, 32'h0);
    tick();
    chk("to_done", {30'h0, m1_done, m0_done}, 32'h2);
    chk("to_exc", {27'h0, m1_exc}, 32'd7);
    chk("to_rdata", m1_rdata, 32'h0);
    m1_req = 1'b0;
    tick();

    // Reset during a device wait aborts it; the tie afterwards goes to m0
    set_m0(1, 0, 4'hF, 32'h0000_7F08, 32'h0);
    tick(); tick(); tick();
    chk("rd_dev_cs_wait", {30'h0, dev_cs}, 32'h1);
    reset = 1'b1;
    tick();
    chk("rd_dev_cs_drop", {30'h0, dev_cs}, 32'h0);
    chk("rd_gnt_drop", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk("rd_rdata_clear", m0_rdata, 32'h0);
    reset = 1'b0;
    m0_req = 1'b0;
    any_done = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (m0_done || m1_done) any_done++;
    end
    chk("rd_no_done", any_done, 32'd0);
    dm_ret = 32'h0BAD_F00D;
    set_m0(1, 0, 4'hF, 32'h0000_0010, 32'h0);
    set_m1(1, 0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    chk("rd_tie_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    m1_req = 1'b0;
    tick(); tick();
    chk("rd_tie_done", {30'h0, m1_done, m0_done}, 32'h1);
    chk("rd_tie_rdata", m0_rdata, 32'h0BAD_F00D);
    m0_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
